// File: rtl/axis_dma_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_dma_packetizer
// Purpose  : Frames an AXI-Stream toward an S2MM DMA so every packet carries
//            tlast. A packet closes on upstream tlast, after MAX_LEN beats,
//            after TIMEOUT idle cycles, or on a flush pulse. The newest beat
//            sits in a hold register until its successor shows up, so tlast
//            can be attached after the fact. A second register (O) drives
//            the master side.
// Revision : 1.0 - initial release
// ============================================================================
module axis_dma_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 256,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  flush_i,
  output logic [31:0]           pkt_cnt_o,
  output logic [15:0]           tmo_cnt_o
);

  // MAX_LEN=1 would give a zero-width index; keep at least one bit.
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDL_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(MAX_LEN - 1);
  localparam logic [IDL_W-1:0] C_TMO      = IDL_W'(TIMEOUT);

  logic                  r_h_valid;
  logic [DATA_WIDTH-1:0] r_h_data;
  logic                  r_h_final;
  logic                  r_o_valid;
  logic [DATA_WIDTH-1:0] r_o_data;
  logic                  r_o_last;
  logic [IDX_W-1:0]      r_beat_idx;
  logic [IDL_W-1:0]      r_idle_cnt;
  logic                  r_flush_pend;
  logic [31:0]           r_pkt_cnt;
  logic [15:0]           r_tmo_cnt;

  logic w_o_free;
  logic w_accept;
  logic w_new_final;
  logic w_flush_req;
  logic w_tmo_hit;
  logic w_mv_push;
  logic w_mv_final;
  logic w_mv_close;
  logic w_o_load;
  logic w_o_last;

  // O can take a beat when empty or when it is draining this cycle.
  assign w_o_free      = !r_o_valid || m_axis_tready;
  assign s_axis_tready = !rst_i && (!r_h_valid || w_o_free);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_new_final   = s_axis_tlast || (r_beat_idx == C_IDX_LAST);
  assign w_flush_req   = flush_i || r_flush_pend;
  assign w_tmo_hit     = (r_idle_cnt == C_TMO);

  // An accept implies O is free, so the push move needs no extra gating.
  // A new beat always beats a timeout/flush close: the packet simply grows.
  assign w_mv_push  = w_accept && r_h_valid;
  assign w_mv_final = !w_accept && r_h_valid && r_h_final && w_o_free;
  assign w_mv_close = !w_accept && r_h_valid && !r_h_final &&
                      (w_tmo_hit || w_flush_req) && w_o_free;
  assign w_o_load   = w_mv_push || w_mv_final || w_mv_close;
  assign w_o_last   = w_mv_push ? r_h_final : 1'b1;

  // Hold register: captures each accepted beat, empties when a close moves it to O
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
      r_h_final <= 1'b0;
    end else if (w_accept) begin
      r_h_valid <= 1'b1;
      r_h_data  <= s_axis_tdata;
      r_h_final <= w_new_final;
    end else if (w_mv_final || w_mv_close) begin
      r_h_valid <= 1'b0;
    end
  end

  // Output register: loads from H, holds steady under backpressure, clears on drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_last  <= 1'b0;
    end else if (w_o_load) begin
      r_o_valid <= 1'b1;
      r_o_data  <= r_h_data;
      r_o_last  <= w_o_last;
    end else if (m_axis_tready) begin
      r_o_valid <= 1'b0;
    end
  end

  // Beat position within the current packet, restarted by any packet close
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat_idx <= '0;
    end else if (w_accept) begin
      r_beat_idx <= w_new_final ? '0 : r_beat_idx + IDX_W'(1);
    end else if (w_mv_close) begin
      r_beat_idx <= '0;
    end
  end

  // Idle timer: runs only while a non-final beat waits in H, saturates at TIMEOUT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idle_cnt <= '0;
    end else if (w_accept) begin
      r_idle_cnt <= '0;
    end else if (r_h_valid && !r_h_final && !w_tmo_hit) begin
      r_idle_cnt <= r_idle_cnt + IDL_W'(1);
    end
  end

  // Flush request memory: survives until the close happens or becomes moot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush_req) begin
      if (!r_h_valid || r_h_final || w_mv_close) begin
        r_flush_pend <= 1'b0;
      end else begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Statistics: packets emitted (wraps) and forced closes (saturates)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pkt_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_o_load && w_o_last) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_mv_close && (r_tmo_cnt != 16'hFFFF)) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = r_o_valid;
  assign m_axis_tdata  = r_o_data;
  assign m_axis_tlast  = r_o_last;
  assign pkt_cnt_o     = r_pkt_cnt;
  assign tmo_cnt_o     = r_tmo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_dma_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_dma_packetizer
// Purpose  : Directed table plus corner-case sequences and a randomised
//            scoreboard run for axis_dma_packetizer (MAX_LEN=4, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_dma_packetizer;

  localparam int DW = 32;
  localparam int ML = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   pkt_cnt;
  logic [15:0]   tmo_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [32:0] exp_q[$];
  logic [32:0] out_log[$];
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          pkt_len = 0;

  always #5 clk = ~clk;

  axis_dma_packetizer #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .flush_i       (flush),
    .pkt_cnt_o     (pkt_cnt),
    .tmo_cnt_o     (tmo_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; all sampling happens on the falling edge.
  task automatic drv(input logic v, input logic [DW-1:0] d, input logic l,
                     input logic r, input logic f);
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = r;
    flush    = f;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    s_tvalid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    drv(0, '0, 0, 1, 0);
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    chk({name, "_drained"}, 64'(k < 60), 64'd1);
  endtask

  // Scoreboard: every accepted beat must leave once, in order, keeping its tlast.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      pkt_len = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, prev_last, prev_data});
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tlast, s_tdata});
        n_acc++;
      end
      if (m_tvalid && m_tready) begin
        out_log.push_back({m_tlast, m_tdata});
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("order_data", 64'(m_tdata), 64'(e[31:0]));
          chk("tlast_kept", 64'(e[32] && !m_tlast), 64'd0);
        end
        pkt_len++;
        chk("pkt_len_le_max", 64'(pkt_len > ML), 64'd0);
        if (m_tlast) pkt_len = 0;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  typedef struct packed {
    logic          sv;
    logic [DW-1:0] sd;
    logic          sl;
    logic          mr;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          er;
    logic [31:0]   ep;
    logic [15:0]   et;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int lat;
    int cyc;
    int base;
    logic [31:0] pkt0;
    logic [15:0] tmo0;

    // Per-cycle table: inputs for the cycle, then outputs seen during it.
    //            sv  sd        sl mr fl  ev  ed        el er  ep  et
    tbl[0]  = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd0, 16'd0};
    tbl[2]  = '{1'b1, 32'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'd0, 16'd0};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 32'd0, 16'd0};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hC3, 1'b1, 1'b1, 32'd1, 16'd0};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd1, 16'd0};
    tbl[6]  = '{1'b1, 32'hD4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd1, 16'd0};
    tbl[7]  = '{1'b1, 32'hE5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd1, 16'd0};
    tbl[8]  = '{1'b1, 32'hF6, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD4, 1'b0, 1'b0, 32'd1, 16'd0};
    tbl[9]  = '{1'b1, 32'hF6, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD4, 1'b0, 1'b0, 32'd1, 16'd0};
    tbl[10] = '{1'b1, 32'hF6, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD4, 1'b0, 1'b1, 32'd1, 16'd0};
    tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hE5, 1'b1, 1'b1, 32'd2, 16'd0};
    tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'd2, 16'd0};
    tbl[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hF6, 1'b1, 1'b1, 32'd3, 16'd1};
    tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'd3, 16'd1};
    tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd3, 16'd1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_tdata),  64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("rst_tmo_cnt",  64'(tmo_cnt),  64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Directed table: 3-beat packet, stall with backpressure, flush close, flush on empty H
    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_m_tvalid", i), 64'(m_tvalid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_m_tdata", i), 64'(m_tdata), 64'(tbl[i].ed));
        chk($sformatf("tbl%0d_m_tlast", i), 64'(m_tlast), 64'(tbl[i].el));
      end
      chk($sformatf("tbl%0d_s_tready", i), 64'(s_tready), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_pkt_cnt", i),  64'(pkt_cnt),  64'(tbl[i].ep));
      chk($sformatf("tbl%0d_tmo_cnt", i),  64'(tmo_cnt),  64'(tbl[i].et));
    end

    // Lone non-final beat: closed by the idle timer TIMEOUT+1 edges after its accept
    drv(1, 32'hDEADBEEF, 0, 1, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (m_tvalid) begin
        lat = k;
        break;
      end
    end
    chk("tmo_latency", 64'(lat), 64'(TO + 1));
    chk("tmo_data", 64'(m_tdata), 64'hDEADBEEF);
    chk("tmo_tlast", 64'(m_tlast), 64'd1);
    wait_drain("tmo");
    chk("tmo_tmo_cnt", 64'(tmo_cnt), 64'd2);

    // Flush while O is stalled: must be remembered and close on the first ready cycle
    out_log.delete();
    pkt0 = pkt_cnt;
    tmo0 = tmo_cnt;
    drv(1, 32'h51, 0, 0, 0);
    drv(1, 32'h52, 0, 0, 0);
    drv(0, 32'h0, 0, 0, 1);
    repeat (3) drv(0, 32'h0, 0, 0, 0);
    @(negedge clk);
    chk("flush_stalled_data", 64'(m_tdata), 64'h51);
    drv(0, 32'h0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("flush_close", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, 1'b1, 32'h52});
    wait_drain("flush");
    chk("flush_log_n", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      chk("flush_log0", 64'(out_log[0]), {31'd0, 1'b0, 32'h51});
      chk("flush_log1", 64'(out_log[1]), {31'd0, 1'b1, 32'h52});
    end
    chk("flush_pkt_cnt", 64'(pkt_cnt), 64'(pkt0 + 32'd1));
    chk("flush_tmo_cnt", 64'(tmo_cnt), 64'(tmo0 + 16'd1));

    // Reset with H and O both full
    drv(1, 32'h61, 0, 0, 0);
    drv(1, 32'h62, 0, 0, 0);
    drv(0, 32'h0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("midrst_tmo_cnt",  64'(tmo_cnt),  64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    out_log.delete();
    drv(1, 32'h71, 0, 1, 0);
    drv(1, 32'h72, 1, 1, 0);
    wait_drain("postrst");
    chk("postrst_log_n", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      chk("postrst_log0", 64'(out_log[0]), {31'd0, 1'b0, 32'h71});
      chk("postrst_log1", 64'(out_log[1]), {31'd0, 1'b1, 32'h72});
    end
    chk("postrst_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("postrst_tmo_cnt", 64'(tmo_cnt), 64'd0);

    // Ten back-to-back untagged beats: MAX_LEN closes after 4 and 8, timer closes 9-10
    do_reset();
    out_log.delete();
    for (int i = 0; i < 10; i++) drv(1, 32'(i + 1), 0, 1, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (m_tvalid && m_tdata == 32'd10) begin
        lat = k;
        break;
      end
    end
    // Beat 10 sits behind the same idle timer as a lone beat.
    chk("len_tmo_latency", 64'(lat), 64'(TO + 1));
    chk("len_tmo_tlast", 64'(m_tlast), 64'd1);
    wait_drain("len");
    chk("len_log_n", 64'(out_log.size()), 64'd10);
    if (out_log.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("len_beat%0d", i + 1), 64'(out_log[i]),
            {31'd0, (i == 3 || i == 7 || i == 9) ? 1'b1 : 1'b0, 32'(i + 1)});
      end
    end
    chk("len_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("len_tmo_cnt", 64'(tmo_cnt), 64'd1);

    // Random traffic and backpressure against the scoreboard
    base = n_acc;
    cyc = 0;
    while ((n_acc - base) < 10000 && cyc < 80000) begin
      @(posedge clk);
      #1;
      s_tvalid = 1'($urandom_range(1));
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(7) == 0);
      m_tready = 1'($urandom_range(1));
      flush    = ($urandom_range(31) == 0);
      cyc++;
    end
    flush = 1'b0;
    chk("rand_progress", 64'((n_acc - base) >= 10000), 64'd1);
    wait_drain("rand");
    chk("rand_all_out", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
